// File: rtl/frame_reader_stream_if.sv
// Pixel stream bus carrying frame-buffer pixels with start/end-of-frame markers
// from the frame reader towards the filter stage and video sink.
interface frame_reader_stream_if;
  logic [11:0] out_pixel;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;

  modport master (
    output out_pixel,
    output out_valid,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  out_pixel,
    input  out_valid,
    input  out_sop,
    input  out_eop,
    output out_ready
  );
endinterface

// File: rtl/frame_reader_stream.sv
// Raster-order frame-buffer reader: issues one read per free FIFO slot and
// presents the returned RGB444 pixels as a ready/valid stream with SOP/EOP.
module frame_reader_stream #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_W-1:0]     rdaddress,
  output logic                  rden,
  input  logic [11:0]           rddata,
  output logic                  frame_done,
  frame_reader_stream_if.master strm
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic              rden_r;
  logic              rden_next_s;
  logic              inflight_r;
  logic              inflight_sop_r;
  logic              inflight_eop_r;
  logic [13:0]       fifo_mem_r [3];
  logic [1:0]        wr_ptr_r;
  logic [1:0]        rd_ptr_r;
  logic [1:0]        count_r;
  logic [1:0]        count_next_s;
  logic              frame_done_r;
  logic [13:0]       head_s;
  logic              valid_s;
  logic              push_s;
  logic              pop_s;
  logic              last_pop_s;
  logic              load_addr_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign valid_s    = (count_r != 2'd0);
  assign push_s     = inflight_r;
  assign pop_s      = valid_s && strm.out_ready;
  assign last_pop_s = pop_s && head_s[12];

  // FIFO occupancy after this edge's push/pop
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_next_s = ST_RUN;
        else        state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (rden_r && (addr_r == LAST_ADDR)) state_next_s = ST_DRAIN;
        else                                 state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (last_pop_s) state_next_s = enable ? ST_RUN : ST_IDLE;
        else            state_next_s = ST_DRAIN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: the read strobe is registered, so decide it from next-cycle occupancy
  always_comb begin
    load_addr_s = 1'b0;
    rden_next_s = 1'b0;
    if ((state_next_s == ST_RUN) && (state_r != ST_RUN)) begin
      load_addr_s = 1'b1;
    end else begin
      load_addr_s = 1'b0;
    end
    if (state_next_s == ST_RUN) begin
      rden_next_s = (({1'b0, count_next_s} + {2'b00, rden_r}) < 3'd3);
    end else begin
      rden_next_s = 1'b0;
    end
  end

  // Read issue: address counter, strobe and tags for the read in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r         <= {ADDR_W{1'b0}};
      rden_r         <= 1'b0;
      inflight_r     <= 1'b0;
      inflight_sop_r <= 1'b0;
      inflight_eop_r <= 1'b0;
    end else begin
      rden_r         <= rden_next_s;
      inflight_r     <= rden_r;
      inflight_sop_r <= rden_r && (addr_r == {ADDR_W{1'b0}});
      inflight_eop_r <= rden_r && (addr_r == LAST_ADDR);
      if (load_addr_s) begin
        addr_r <= {ADDR_W{1'b0}};
      end else if (rden_r && (addr_r != LAST_ADDR)) begin
        addr_r <= addr_r + ADDR_W'(1);
      end
    end
  end

  // Three-entry skid FIFO and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) fifo_mem_r[i] <= 14'd0;
      wr_ptr_r     <= 2'd0;
      rd_ptr_r     <= 2'd0;
      count_r      <= 2'd0;
      frame_done_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {inflight_sop_r, inflight_eop_r, rddata};
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r      <= count_next_s;
      frame_done_r <= last_pop_s;
    end
  end

  // Stream outputs show the FIFO head; markers and pixel read zero while empty
  always_comb begin
    strm.out_valid = valid_s;
    if (valid_s) begin
      strm.out_pixel = head_s[11:0];
      strm.out_sop   = head_s[13];
      strm.out_eop   = head_s[12];
    end else begin
      strm.out_pixel = 12'd0;
      strm.out_sop   = 1'b0;
      strm.out_eop   = 1'b0;
    end
  end

  assign rdaddress  = addr_r;
  assign rden       = rden_r;
  assign frame_done = frame_done_r;
endmodule

// File: tb/tb_frame_reader_stream.sv
// Directed bench for frame_reader_stream on a 4x2 frame, with a stream-level
// reference model checked every cycle plus hand-computed timing checks.
module tb_frame_reader_stream;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] rdaddress;
  logic          rden;
  logic [11:0]   rddata;
  logic          frame_done;
  logic [11:0]   ram [N];

  frame_reader_stream_if strm ();

  frame_reader_stream #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rdaddress  (rdaddress),
    .rden       (rden),
    .rddata     (rddata),
    .frame_done (frame_done),
    .strm       (strm)
  );

  always #5 clk = ~clk;

  // Frame buffer with one-cycle read latency
  always @(posedge clk) rddata <= ram[rdaddress];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream-level model: pixels leave in raster order, reads never exceed 3 outstanding
  int          exp_idx     = 0;
  int          exp_addr    = 0;
  int          outstanding = 0;
  int          rd_count    = 0;
  int          acc_count   = 0;
  int          done_count  = 0;
  bit          exp_done    = 1'b0;
  bit          prev_stall  = 1'b0;
  logic [13:0] prev_out    = 14'd0;

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      exp_idx     = 0;
      exp_addr    = 0;
      outstanding = 0;
      exp_done    = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      if (frame_done) done_count++;
      exp_done = 1'b0;
      if (prev_stall)
        chk("hold", {17'd0, strm.out_valid, strm.out_sop, strm.out_eop, strm.out_pixel},
            {17'd0, 1'b1, prev_out});
      if (rden) begin
        chk("rden_room", 32'(outstanding < 3), 32'd1);
        chk("rdaddress", 32'(rdaddress), 32'(exp_addr));
        exp_addr = (exp_addr + 1) % N;
        outstanding++;
        rd_count++;
      end
      if (strm.out_valid && strm.out_ready) begin
        chk("pixel", 32'(strm.out_pixel), 32'(ram[exp_idx]));
        chk("sop", 32'(strm.out_sop), 32'(exp_idx == 0));
        chk("eop", 32'(strm.out_eop), 32'(exp_idx == N - 1));
        if (exp_idx == N - 1) exp_done = 1'b1;
        exp_idx = (exp_idx + 1) % N;
        outstanding--;
        acc_count++;
      end
      prev_stall = strm.out_valid && !strm.out_ready;
      prev_out   = {strm.out_sop, strm.out_eop, strm.out_pixel};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rd0;
    int          acc0;
    bit          seen;
    logic [3:0]  ready_pat;

    for (int i = 0; i < N; i++) ram[i] = 12'(i);
    reset          = 1'b1;
    enable         = 1'b0;
    strm.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", 32'(strm.out_valid), 32'd0);
    chk("rst_rden", 32'(rden), 32'd0);
    chk("rst_addr", 32'(rdaddress), 32'd0);
    chk("rst_sop", 32'(strm.out_sop), 32'd0);
    chk("rst_eop", 32'(strm.out_eop), 32'd0);
    chk("rst_pixel", 32'(strm.out_pixel), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);

    // Frame with ready held high: exact cycle-by-cycle timing
    enable = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) enable = 1'b0;
      chk("t1_valid", 32'(strm.out_valid), 32'(c >= 3 && c <= 10));
      chk("t1_rden", 32'(rden), 32'(c <= 8));
      if (c <= 8) chk("t1_addr", 32'(rdaddress), 32'(c - 1));
      if (c >= 3 && c <= 10) begin
        chk("t1_pixel", 32'(strm.out_pixel), 32'(c - 3));
        chk("t1_sop", 32'(strm.out_sop), 32'(c == 3));
        chk("t1_eop", 32'(strm.out_eop), 32'(c == 10));
      end
      chk("t1_done", 32'(frame_done), 32'(c == 11));
    end

    // Frame with ready pattern 1,0,0,1
    rd0       = rd_count;
    acc0      = acc_count;
    ready_pat = 4'b1001;
    enable    = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      strm.out_ready = ready_pat[i % 4];
      tick();
      enable = 1'b0;
      if (frame_done) seen = 1'b1;
    end
    chk("t2_done", 32'(seen), 32'd1);
    chk("t2_reads", 32'(rd_count - rd0), 32'd8);
    chk("t2_accepts", 32'(acc_count - acc0), 32'd8);
    strm.out_ready = 1'b1;
    tick();

    // Ready held low: three reads then stall with pixel 0 at the head
    rd0            = rd_count;
    strm.out_ready = 1'b0;
    enable         = 1'b1;
    tick();
    enable = 1'b0;
    repeat (24) tick();
    chk("t3_reads", 32'(rd_count - rd0), 32'd3);
    chk("t3_rden", 32'(rden), 32'd0);
    chk("t3_valid", 32'(strm.out_valid), 32'd1);
    chk("t3_pixel", 32'(strm.out_pixel), 32'h000);
    chk("t3_sop", 32'(strm.out_sop), 32'd1);
    strm.out_ready = 1'b1;
    wait_done(40, "t3_done");
    tick();

    // Back-to-back frames with enable held high
    for (int i = 0; i < N; i++) ram[i] = 12'(i) ^ 12'hABC;
    enable = 1'b1;
    wait_done(40, "t4_done1");
    chk("t4_rden", 32'(rden), 32'd1);
    chk("t4_addr", 32'(rdaddress), 32'd0);
    tick();
    tick();
    enable = 1'b0;
    chk("t4_valid", 32'(strm.out_valid), 32'd1);
    chk("t4_sop", 32'(strm.out_sop), 32'd1);
    chk("t4_pixel", 32'(strm.out_pixel), 32'hABC);
    wait_done(40, "t4_done2");
    tick();

    // Reset in the middle of a frame at pixel 5
    for (int i = 0; i < N; i++) ram[i] = 12'(i);
    done_count = 0;
    enable     = 1'b1;
    tick();
    enable = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (strm.out_valid && strm.out_pixel == 12'h005) seen = 1'b1;
      else tick();
    end
    chk("t5_reach5", 32'(seen), 32'd1);
    reset = 1'b1;
    tick();
    chk("t5_valid", 32'(strm.out_valid), 32'd0);
    chk("t5_rden", 32'(rden), 32'd0);
    chk("t5_done", 32'(frame_done), 32'd0);
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("t5_rden1", 32'(rden), 32'd1);
    chk("t5_addr", 32'(rdaddress), 32'd0);
    tick();
    tick();
    chk("t5_valid1", 32'(strm.out_valid), 32'd1);
    chk("t5_sop", 32'(strm.out_sop), 32'd1);
    chk("t5_pixel", 32'(strm.out_pixel), 32'h000);
    wait_done(40, "t5_newdone");
    tick();
    chk("t5_done_count", 32'(done_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
